// File: rtl/lcd_pkg.sv
// Shared types and constants for the HD44780 write-only LCD driver.
// Used by lcd_hd44780_ctrl (optional cursor tracking: LCD_AUTO_WRAP_EN) and lcd_init_rom.
package lcd_pkg;

    // Controller FSM states
    typedef enum logic [2:0] {
        ST_PWRUP,
        ST_INIT_SETUP,
        ST_INIT_PULSE,
        ST_INIT_WAIT,
        ST_IDLE,
        ST_SETUP,
        ST_PULSE,
        ST_WAIT
    } lcd_state_t;

    // Execution-wait class of a transferred byte
    typedef enum logic [1:0] {
        WC_CMD,
        WC_CLR,
        WC_INIT
    } lcd_wclass_t;

    localparam logic [7:0] LCD_CMD_CLEAR   = 8'h01;
    localparam logic [7:0] LCD_CMD_HOME    = 8'h02;
    localparam logic [7:0] LCD_CMD_LINE0   = 8'h80;
    localparam logic [7:0] LCD_CMD_LINE1   = 8'hC0;
    localparam logic [7:0] LCD_CMD_FUNCSET = 8'h38;
    localparam logic [7:0] LCD_CMD_DISPON  = 8'h0C;
    localparam logic [7:0] LCD_CMD_ENTRY   = 8'h06;

    localparam int LCD_INIT_LEN = 6;

    // Clear (0x00/0x01) and home (0x02/0x03) need the long execution wait
    function automatic logic lcd_is_long(input logic rs, input logic [7:0] d);
        return !rs && (d[7:2] == 6'd0);
    endfunction

endpackage

// File: rtl/lcd_init_rom.sv
// Power-up init sequence: index -> {byte, wait class}. Purely combinational.
module lcd_init_rom
    import lcd_pkg::*;
(
    input  logic [2:0]  i_idx,
    output logic [7:0]  o_byte,
    output lcd_wclass_t o_wclass
);

    // Sequence 0x38 x3, 0x0C, 0x01, 0x06; first entry waits longest, clear waits long
    always_comb begin
        o_byte   = LCD_CMD_FUNCSET;
        o_wclass = WC_CMD;
        case (i_idx)
            3'd0: o_wclass = WC_INIT;
            3'd3: o_byte   = LCD_CMD_DISPON;
            3'd4: begin
                o_byte   = LCD_CMD_CLEAR;
                o_wclass = WC_CLR;
            end
            3'd5: o_byte   = LCD_CMD_ENTRY;
            default: ;
        endcase
    end

endmodule

// File: rtl/lcd_hd44780_ctrl.sv
// Timing-correct write-only HD44780 driver: power-up init, then one byte per
// valid/ready request with setup, E pulse and execution wait.
// Define LCD_AUTO_WRAP_EN to track the cursor and auto-issue line changes.
module lcd_hd44780_ctrl
    import lcd_pkg::*;
#(
    parameter int POWERUP_CYC   = 750000,
    parameter int INIT_WAIT_CYC = 205000,
    parameter int E_PULSE_CYC   = 25,
    parameter int CMD_WAIT_CYC  = 2500,
    parameter int CLR_WAIT_CYC  = 82000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic       req_rs,
    input  logic [7:0] req_data,
    output logic       init_done,
    output logic [7:0] lcd_data_bus,
    output logic       lcd_rs,
    output logic       lcd_rw,
    output logic       lcd_e
);

    localparam int M0   = (POWERUP_CYC > INIT_WAIT_CYC) ? POWERUP_CYC : INIT_WAIT_CYC;
    localparam int M1   = (M0 > E_PULSE_CYC) ? M0 : E_PULSE_CYC;
    localparam int M2   = (M1 > CMD_WAIT_CYC) ? M1 : CMD_WAIT_CYC;
    localparam int MAXC = (M2 > CLR_WAIT_CYC) ? M2 : CLR_WAIT_CYC;
    localparam int CW   = $clog2(MAXC + 1);

    lcd_state_t  r_state, w_nstate;
    logic [CW-1:0] r_cnt, w_load_val;
    logic        w_load, w_done, w_accept, w_wrap_go;
    logic [2:0]  r_idx, w_rom_idx;
    logic [7:0]  r_data, w_rom_byte, w_wrap_byte;
    logic        r_rs, r_e, r_ready, r_init_done;
    lcd_wclass_t r_wclass, w_rom_wc;

    function automatic logic [CW-1:0] wait_load(input lcd_wclass_t wc);
        case (wc)
            WC_INIT: return CW'(INIT_WAIT_CYC - 1);
            WC_CLR:  return CW'(CLR_WAIT_CYC - 1);
            default: return CW'(CMD_WAIT_CYC - 1);
        endcase
    endfunction

    assign w_done    = (r_cnt == '0);
    assign w_accept  = (r_state == ST_IDLE) && req_valid;
    assign w_rom_idx = (r_state == ST_PWRUP) ? 3'd0 : r_idx + 3'd1;

    lcd_init_rom u_rom (
        .i_idx    (w_rom_idx),
        .o_byte   (w_rom_byte),
        .o_wclass (w_rom_wc)
    );

`ifdef LCD_AUTO_WRAP_EN
    logic       r_line, r_wrap_pend;
    logic [3:0] r_col;

    assign w_wrap_go   = (r_state == ST_WAIT) && w_done && r_wrap_pend;
    assign w_wrap_byte = r_line ? LCD_CMD_LINE1 : LCD_CMD_LINE0;

    // Cursor tracking; line flips as the 16th char is accepted so the wrap byte is ready
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_line      <= 1'b0;
            r_col       <= 4'd0;
            r_wrap_pend <= 1'b0;
        end else if (w_accept) begin
            if (req_rs) begin
                if (r_col == 4'd15) begin
                    r_col       <= 4'd0;
                    r_line      <= ~r_line;
                    r_wrap_pend <= 1'b1;
                end else begin
                    r_col <= r_col + 4'd1;
                end
            end else if (lcd_is_long(req_rs, req_data)) begin
                r_line <= 1'b0;
                r_col  <= 4'd0;
            end else if (req_data[7]) begin
                r_line <= req_data[6];
                r_col  <= req_data[3:0];
            end
        end else if (w_wrap_go) begin
            r_wrap_pend <= 1'b0;
        end
    end
`else
    assign w_wrap_go   = 1'b0;
    assign w_wrap_byte = 8'h00;
`endif

    // State register and the shared down-counter (loads on state entry, holds at 0)
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_PWRUP;
            r_cnt   <= CW'(POWERUP_CYC - 1);
        end else begin
            r_state <= w_nstate;
            if (w_load)
                r_cnt <= w_load_val;
            else if (!w_done)
                r_cnt <= r_cnt - CW'(1);
        end
    end

    // Next-state and counter-load decode
    always_comb begin
        w_nstate   = r_state;
        w_load     = 1'b0;
        w_load_val = '0;
        case (r_state)
            ST_PWRUP: if (w_done) begin
                w_nstate = ST_INIT_SETUP;
                w_load   = 1'b1;
            end
            ST_INIT_SETUP: begin
                w_nstate   = ST_INIT_PULSE;
                w_load     = 1'b1;
                w_load_val = CW'(E_PULSE_CYC - 1);
            end
            ST_INIT_PULSE: if (w_done) begin
                w_nstate   = ST_INIT_WAIT;
                w_load     = 1'b1;
                w_load_val = wait_load(r_wclass);
            end
            ST_INIT_WAIT: if (w_done) begin
                w_load   = 1'b1;
                w_nstate = (r_idx == 3'(LCD_INIT_LEN - 1)) ? ST_IDLE : ST_INIT_SETUP;
            end
            ST_IDLE: if (req_valid) begin
                w_nstate = ST_SETUP;
                w_load   = 1'b1;
            end
            ST_SETUP: begin
                w_nstate   = ST_PULSE;
                w_load     = 1'b1;
                w_load_val = CW'(E_PULSE_CYC - 1);
            end
            ST_PULSE: if (w_done) begin
                w_nstate   = ST_WAIT;
                w_load     = 1'b1;
                w_load_val = wait_load(r_wclass);
            end
            ST_WAIT: if (w_done) begin
                w_load   = 1'b1;
                w_nstate = w_wrap_go ? ST_SETUP : ST_IDLE;
            end
            default: w_nstate = ST_PWRUP;
        endcase
    end

    // Registered LCD pins and handshake; bus/RS load only when a new byte starts
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_e         <= 1'b0;
            r_ready     <= 1'b0;
            r_init_done <= 1'b0;
            r_idx       <= 3'd0;
            r_data      <= 8'h00;
            r_rs        <= 1'b0;
            r_wclass    <= WC_CMD;
        end else begin
            r_e     <= (w_nstate == ST_INIT_PULSE) || (w_nstate == ST_PULSE);
            r_ready <= (w_nstate == ST_IDLE);
            if (w_nstate == ST_IDLE)
                r_init_done <= 1'b1;
            if (w_nstate == ST_INIT_SETUP) begin
                r_idx    <= w_rom_idx;
                r_data   <= w_rom_byte;
                r_rs     <= 1'b0;
                r_wclass <= w_rom_wc;
            end else if (w_accept) begin
                r_data   <= req_data;
                r_rs     <= req_rs;
                r_wclass <= lcd_is_long(req_rs, req_data) ? WC_CLR : WC_CMD;
            end else if (w_wrap_go) begin
                r_data   <= w_wrap_byte;
                r_rs     <= 1'b0;
                r_wclass <= WC_CMD;
            end
        end
    end

    assign req_ready    = r_ready;
    assign init_done    = r_init_done;
    assign lcd_data_bus = r_data;
    assign lcd_rs       = r_rs;
    assign lcd_rw       = 1'b0;
    assign lcd_e        = r_e;

endmodule

// File: tb/tb_lcd_hd44780_ctrl.sv
// Directed self-checking bench for lcd_hd44780_ctrl with shortened timings.
// Build with LCD_AUTO_WRAP_EN defined to also exercise the cursor wrap.
module tb_lcd_hd44780_ctrl;

    localparam int PWR = 20;
    localparam int IW  = 10;
    localparam int E   = 3;
    localparam int CMW = 5;
    localparam int CLW = 12;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       req_valid = 1'b0;
    logic       req_rs = 1'b0;
    logic [7:0] req_data = 8'h00;
    logic       req_ready, init_done, lcd_rs, lcd_rw, lcd_e;
    logic [7:0] lcd_data_bus;

    int errors = 0;
    int checks = 0;

    logic [7:0] rom_b [0:5] = '{8'h38, 8'h38, 8'h38, 8'h0C, 8'h01, 8'h06};
    int         gap_w [0:5] = '{IW, CMW, CMW, CMW, CLW, CMW};

    lcd_hd44780_ctrl #(
        .POWERUP_CYC(PWR), .INIT_WAIT_CYC(IW), .E_PULSE_CYC(E),
        .CMD_WAIT_CYC(CMW), .CLR_WAIT_CYC(CLW)
    ) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
        .req_rs(req_rs), .req_data(req_data), .init_done(init_done),
        .lcd_data_bus(lcd_data_bus), .lcd_rs(lcd_rs), .lcd_rw(lcd_rw), .lcd_e(lcd_e)
    );

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got 0x%0h want 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic int exp_w(input logic rs, input logic [7:0] d);
        return (rs == 1'b0 && d <= 8'h03) ? CLW : CMW;
    endfunction

    // Count consecutive samples with lcd_e at lvl (stops early when ready shows)
    task automatic cnt_e(input logic lvl, output int n);
        n = 0;
        while (lcd_e === lvl && req_ready !== 1'b1 && n < 2000) begin
            tick();
            n++;
        end
    endtask

    task automatic wait_ready();
        int n = 0;
        while (req_ready !== 1'b1 && n < 500) begin
            tick();
            n++;
        end
        chk("ready_wait", req_ready, 1);
    endtask

    // Called on the first sample after reset release
    task automatic init_check();
        int n;
        cnt_e(1'b0, n);
        chk("pwrup_low", n, PWR + 1);   // power-up cycles plus first setup cycle
        for (int i = 0; i < 6; i++) begin
            chk("init_pulse_bus", {init_done, req_ready, lcd_rs, lcd_data_bus}, {3'b000, rom_b[i]});
            cnt_e(1'b1, n);
            chk("init_pulse_len", n, E);
            chk("init_hold", {lcd_rs, lcd_data_bus}, {1'b0, rom_b[i]});
            cnt_e(1'b0, n);
            chk("init_gap", n, (i == 5) ? gap_w[i] : gap_w[i] + 1);
        end
        chk("init_end", {init_done, req_ready, lcd_e}, 3'b110);
    endtask

    // From the setup sample: check setup, pulse and wait phases
    task automatic phases(input logic rs, input logic [7:0] d, input int w);
        chk("setup", {lcd_e, req_ready, lcd_rs, lcd_data_bus}, {2'b00, rs, d});
        repeat (E) begin
            tick();
            chk("pulse", {lcd_e, req_ready, lcd_rs, lcd_data_bus}, {2'b10, rs, d});
        end
        repeat (w) begin
            tick();
            chk("wait", {lcd_e, req_ready, lcd_rs, lcd_data_bus}, {2'b00, rs, d});
        end
    endtask

    task automatic send(input logic rs, input logic [7:0] d, input bit wrap, input logic [7:0] wb);
        wait_ready();
        req_valid = 1'b1;
        req_rs    = rs;
        req_data  = d;
        tick();
        req_valid = 1'b0;
        req_rs    = ~rs;
        req_data  = 8'($urandom);
        phases(rs, d, exp_w(rs, d));
        tick();
        if (wrap) begin
            phases(1'b0, wb, CMW);
            tick();
        end
        chk("ready_back", {lcd_e, req_ready}, 2'b01);
    endtask

    initial begin
        int cyc, acc, pul;
        logic [7:0] d_drv, exp_d;
        logic rdy_prev, e_prev;

        // Reset state and first init sequence
        tick();
        tick();
        chk("reset_outs", {lcd_e, lcd_rs, lcd_rw, lcd_data_bus, req_ready, init_done}, 0);
        reset = 1'b1;
        init_check();

        // Character and command transfers, including wait-class boundaries
        send(1'b1, 8'h41, 1'b0, 8'h00);
        send(1'b0, 8'h01, 1'b0, 8'h00);
        send(1'b0, 8'h80, 1'b0, 8'h00);
        send(1'b0, 8'h03, 1'b0, 8'h00);
        send(1'b0, 8'h04, 1'b0, 8'h00);
        send(1'b1, 8'h01, 1'b0, 8'h00);
        send(1'b0, 8'h00, 1'b0, 8'h00);

        // Valid held high with data changing every cycle
        wait_ready();
        cyc = 0; acc = 0; pul = 0; exp_d = 8'h00;
        req_valid = 1'b1;
        req_rs    = 1'b1;
        while (cyc < 300) begin
            if (req_ready === 1'b1 && acc == 4) break;
            d_drv    = 8'($urandom);
            req_data = d_drv;
            rdy_prev = req_ready;
            e_prev   = lcd_e;
            tick();
            cyc++;
            if (rdy_prev === 1'b1) begin
                acc++;
                exp_d = d_drv;
            end
            if (lcd_e === 1'b1 && e_prev === 1'b0) begin
                pul++;
                chk("t4_pulse_data", {lcd_rs, lcd_data_bus}, {1'b1, exp_d});
            end
            if (req_ready !== 1'b1)
                chk("t4_hold", {lcd_rs, lcd_data_bus}, {1'b1, exp_d});
        end
        req_valid = 1'b0;
        chk("t4_accepts", acc, 4);
        chk("t4_pulses", pul, 4);
        chk("t4_cycles", cyc, 4 * (1 + E + CMW + 1));

        // Reset during the E pulse
        wait_ready();
        req_valid = 1'b1;
        req_rs    = 1'b1;
        req_data  = 8'h55;
        tick();
        req_valid = 1'b0;
        tick();
        tick();
        chk("t5_in_pulse", {lcd_e, lcd_data_bus}, {1'b1, 8'h55});
        #2;
        reset = 1'b0;
        #1;
        chk("t5_async_clear", {lcd_e, lcd_rs, lcd_rw, lcd_data_bus, req_ready, init_done}, 0);
        tick();
        tick();
        reset = 1'b1;
        init_check();

`ifdef LCD_AUTO_WRAP_EN
        send(1'b0, 8'h01, 1'b0, 8'h00);
        for (int i = 0; i < 16; i++)
            send(1'b1, 8'(8'h30 + i), i == 15, 8'hC0);
        for (int i = 0; i < 16; i++)
            send(1'b1, 8'(8'h40 + i), i == 15, 8'h80);
        send(1'b0, 8'h01, 1'b0, 8'h00);
        for (int i = 0; i < 16; i++)
            send(1'b1, 8'(8'h50 + i), i == 15, 8'hC0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
